sram_scan_sequencer: RTL and testbench
======================================

Name: sram_scan_sequencer

Overview:
- Hardware sequencer for the GPIO scan-chain SRAM test path. Replaces bit-banged GPIO stimulus with an on-chip engine.
- Accepts one parallel 112-bit SRAM command and serialises it into the scan chain. Pulses global CSB, and for reads loads the dout flops and captures the 112-bit scan-out.
- Sits in the user project between a Wishbone/LA command register block and the scan chain's scan/sram_load/global_csb/serial pins.

Parameters:
- SCAN_WIDTH, 112, scan packet length in bits.
- CSB_CYCLES, 1, cycles global_csb_o is held low per access (1..15).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  sequencer idle, accepts command
- cmd_read_i  in  1  1 = read (scan-out phase), 0 = write
- cmd_data_i  in  SCAN_WIDTH  packet {sel, addr0, din0, csb0, web0, mask0, addr1, din1, csb1, web1, mask1}
- rsp_valid_o  out  1  operation complete
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  SCAN_WIDTH  captured scan-out (reads); zero for writes
- scan_en_o  out  1  chain shift enable
- scan_out_o  out  1  serial data into chain, MSB first
- scan_in_i  in  1  serial data from chain
- sram_load_o  out  1  load SRAM dout into scan flops
- global_csb_o  out  1  global chip select, active low

Behaviour:
- Reset values:
  - cmd_ready_o=1; rsp_valid_o=0; rsp_data_o=0.
  - scan_en_o=0; scan_out_o=0; sram_load_o=0; global_csb_o=1.
  - State IDLE; bit counter 0.
- Reset mid-operation aborts immediately to the reset values. No partial response is issued.
- Handshake: a command is accepted on a clock edge with cmd_valid_i & cmd_ready_o. cmd_ready_o=1 only in IDLE. cmd_data_i and cmd_read_i are registered on acceptance.
- States and transitions:
  - IDLE -> SHIFT_IN on acceptance.
  - SHIFT_IN, SCAN_WIDTH cycles: scan_en_o=1; scan_out_o=shreg[MSB]; shreg shifts left each cycle; counter counts 0..SCAN_WIDTH-1. Exit to ACCESS when counter = SCAN_WIDTH-1.
  - ACCESS, CSB_CYCLES cycles: scan_en_o=0; global_csb_o=0. Exit to STORE if read, DONE if write.
  - STORE, 1 cycle: global_csb_o=1; dout flops capture the read.
  - LOAD, 1 cycle: sram_load_o=1.
  - SHIFT_OUT, SCAN_WIDTH cycles: scan_en_o=1. scan_in_i is sampled at each rising edge into shreg LSB, shifting left. The first sampled bit ends as rsp_data_o[MSB].
  - DONE: rsp_valid_o=1; rsp_data_o=shreg for reads, 0 for writes. Held stable until rsp_ready_i, then -> IDLE.
- Latency, with acceptance at edge 0:
  - Write: rsp_valid_o high in cycle SCAN_WIDTH+CSB_CYCLES+1 (114 at defaults).
  - Read: rsp_valid_o high in cycle 2*SCAN_WIDTH+CSB_CYCLES+3 (228 at defaults).
- rsp_ready_i asserted together with rsp_valid_o: response consumed that edge. cmd_ready_o rises the following cycle (no same-cycle re-accept).
- Outputs are driven from registers only (glitch-free pins).
- cmd_valid_i outside IDLE is ignored.
- Counter is sized $clog2(SCAN_WIDTH)+1 bits and is cleared on every state entry. There is no wrap-around past SCAN_WIDTH-1.

Optional Feature:
- Macro: SRAM_SCAN_CHECK_EN.
- When defined:
  - Extra input exp_data_i[SCAN_WIDTH], latched on acceptance.
  - Extra outputs rsp_mismatch_o (1) and mismatch_cnt_o (8, saturating).
  - In SHIFT_OUT, each sampled bit is compared against the expected bit with X/Z treated as mismatch.
  - rsp_mismatch_o is valid with rsp_valid_o. mismatch_cnt_o increments once per mismatching read and clears on reset.
- When undefined: these ports and this logic are absent.

Decomposition:
- Package sram_scan_pkg contains:
  - SCAN_WIDTH.
  - Field offset/width localparams: SEL 111:108, ADDR0 107:92, DIN0 91:60, CSB0 59, WEB0 58, MASK0 57:54, ADDR1 53:38, DIN1 37:6, CSB1 5, WEB1 4, MASK1 3:0.
  - State enum {IDLE, SHIFT_IN, ACCESS, STORE, LOAD, SHIFT_OUT, DONE}.
- One sub-module, scan_shift_reg: parallel load, serial in/out, shift enable.

Test Plan:
- Reset mid-SHIFT_IN (cycle 50) -> global_csb_o=1, scan_en_o=0, cmd_ready_o=1 next cycle; no rsp_valid_o.
- Write, sel=0, addr0=1, din0=32'h0, csb0=0, web0=0, port1 disabled -> 112 serial bits match packet MSB first; global_csb_o low exactly 1 cycle; rsp_valid_o at cycle 114; rsp_data_o=0.
- Read, sel=9, addr0=1/addr1=2, behavioural chain model returning din0=9, din1=72 -> sram_load_o pulses 1 cycle after the CSB rise; rsp_data_o equals packet with those din fields; rsp_valid_o at cycle 228.
- Read, sel=11 (ROM), addr0=1, chain returns din0=32'd255 -> rsp_data_o[91:60]=255.
- rsp_ready_i held low 20 cycles -> rsp_valid_o/rsp_data_o stable; cmd_valid_i during this window not accepted.
- SRAM_SCAN_CHECK_EN: exp din0=32'hDEADBEEF, chain returns 32'hDEADBEEE -> rsp_mismatch_o=1, mismatch_cnt_o=1.

Source files
------------

// File: rtl/sram_scan_pkg.sv
// Shared definitions for the SRAM scan-chain sequencer: packet geometry, field offsets and FSM states.
package sram_scan_pkg;

  localparam int SCAN_WIDTH = 112;

  localparam int SEL_MSB   = 111;
  localparam int SEL_LSB   = 108;
  localparam int ADDR0_MSB = 107;
  localparam int ADDR0_LSB = 92;
  localparam int DIN0_MSB  = 91;
  localparam int DIN0_LSB  = 60;
  localparam int CSB0_BIT  = 59;
  localparam int WEB0_BIT  = 58;
  localparam int MASK0_MSB = 57;
  localparam int MASK0_LSB = 54;
  localparam int ADDR1_MSB = 53;
  localparam int ADDR1_LSB = 38;
  localparam int DIN1_MSB  = 37;
  localparam int DIN1_LSB  = 6;
  localparam int CSB1_BIT  = 5;
  localparam int WEB1_BIT  = 4;
  localparam int MASK1_MSB = 3;
  localparam int MASK1_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    ACCESS,
    STORE,
    LOAD,
    SHIFT_OUT,
    DONE
  } state_e;

  function automatic logic [SCAN_WIDTH-1:0] pack_cmd(
    input logic [3:0]  sel,
    input logic [15:0] addr0,
    input logic [31:0] din0,
    input logic        csb0,
    input logic        web0,
    input logic [3:0]  mask0,
    input logic [15:0] addr1,
    input logic [31:0] din1,
    input logic        csb1,
    input logic        web1,
    input logic [3:0]  mask1
  );
    return {sel, addr0, din0, csb0, web0, mask0, addr1, din1, csb1, web1, mask1};
  endfunction

endpackage

// File: rtl/sram_scan_sequencer_shreg.sv
// scan_shift_reg: parallel-load, shift-left register with serial LSB input; nxt_o exposes the
// value it will hold after the coming edge so the owner can register pins from it.
module scan_shift_reg #(
  parameter int WIDTH = 112
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] nxt_o
);
  import sram_scan_pkg::*;

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = load_dat_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], ser_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign nxt_o = shreg_d;

endmodule

// File: rtl/sram_scan_sequencer.sv
// sram_scan_sequencer: one command -> scan-in, CSB strobe, optional dout load + scan-out; SRAM_SCAN_CHECK_EN adds expected-data compare.
// Response after W+C+1 cycles (write) / 2W+C+3 (read); busy until the response is consumed, cmd_valid_i ignored meanwhile.
module sram_scan_sequencer #(
  parameter int SCAN_WIDTH = sram_scan_pkg::SCAN_WIDTH,
  parameter int CSB_CYCLES = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_read_i,
  input  logic [SCAN_WIDTH-1:0] cmd_data_i,
`ifdef SRAM_SCAN_CHECK_EN
  input  logic [SCAN_WIDTH-1:0] exp_data_i,
  output logic                  rsp_mismatch_o,
  output logic [7:0]            mismatch_cnt_o,
`endif
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [SCAN_WIDTH-1:0] rsp_data_o,
  output logic                  scan_en_o,
  output logic                  scan_out_o,
  input  logic                  scan_in_i,
  output logic                  sram_load_o,
  output logic                  global_csb_o
);
  import sram_scan_pkg::*;

  localparam int CW = $clog2(SCAN_WIDTH) + 1;
  localparam logic [CW-1:0] SHIFT_LAST = CW'(SCAN_WIDTH - 1);
  localparam logic [CW-1:0] CSB_LAST   = CW'(CSB_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  read_q, read_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [SCAN_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  scan_en_q, scan_en_d;
  logic                  scan_out_q, scan_out_d;
  logic                  sram_load_q, sram_load_d;
  logic                  global_csb_q, global_csb_d;

  logic                  accept;
  logic                  sh_shift;
  logic [SCAN_WIDTH-1:0] sh_nxt;

  assign accept   = (state_q == IDLE) && cmd_valid_i;
  assign sh_shift = (state_q == SHIFT_IN) || (state_q == SHIFT_OUT);

  scan_shift_reg #(
    .WIDTH (SCAN_WIDTH)
  ) u_shreg (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (accept),
    .load_dat_i (cmd_data_i),
    .shift_i    (sh_shift),
    .ser_i      (scan_in_i),
    .nxt_o      (sh_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cmd_valid_i) state_d = SHIFT_IN;
      SHIFT_IN:  if (cnt_q == SHIFT_LAST) state_d = ACCESS;
      ACCESS:    if (cnt_q == CSB_LAST) state_d = read_q ? STORE : DONE;
      STORE:     state_d = LOAD;
      LOAD:      state_d = SHIFT_OUT;
      SHIFT_OUT: if (cnt_q == SHIFT_LAST) state_d = DONE;
      DONE:      if (rsp_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Pins are registered from the next state so they line up with the state they describe.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == SHIFT_IN) || (state_q == ACCESS) || (state_q == SHIFT_OUT))) begin
      cnt_d = cnt_q + CW'(1);
    end

    read_d       = accept ? cmd_read_i : read_q;
    cmd_ready_d  = (state_d == IDLE);
    scan_en_d    = (state_d == SHIFT_IN) || (state_d == SHIFT_OUT);
    scan_out_d   = (state_d == SHIFT_IN) ? sh_nxt[SCAN_WIDTH-1] : 1'b0;
    sram_load_d  = (state_d == LOAD);
    global_csb_d = (state_d != ACCESS);
    rsp_valid_d  = (state_d == DONE);

    rsp_data_d = '0;
    if ((state_q == SHIFT_OUT) && (state_d == DONE)) begin
      rsp_data_d = sh_nxt;
    end else if (state_d == DONE) begin
      rsp_data_d = rsp_data_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      scan_en_q    <= 1'b0;
      scan_out_q   <= 1'b0;
      sram_load_q  <= 1'b0;
      global_csb_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_q       <= read_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      scan_en_q    <= scan_en_d;
      scan_out_q   <= scan_out_d;
      sram_load_q  <= sram_load_d;
      global_csb_q <= global_csb_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign scan_en_o    = scan_en_q;
  assign scan_out_o   = scan_out_q;
  assign sram_load_o  = sram_load_q;
  assign global_csb_o = global_csb_q;

`ifdef SRAM_SCAN_CHECK_EN
  logic [SCAN_WIDTH-1:0] exp_q, exp_d;
  logic                  bit_mm;
  logic                  mm_acc_q, mm_acc_d;
  logic                  rsp_mm_q, rsp_mm_d;
  logic [7:0]            mcnt_q, mcnt_d;

  always_comb begin
    exp_d = exp_q;
    if (accept) begin
      exp_d = exp_data_i;
    end else if (state_q == SHIFT_OUT) begin
      exp_d = {exp_q[SCAN_WIDTH-2:0], 1'b0};
    end

    // === makes an X/Z from the chain count as a mismatch; hardware sees a plain equality.
    bit_mm = 1'b0;
    if (state_q == SHIFT_OUT) begin
      bit_mm = (scan_in_i === exp_q[SCAN_WIDTH-1]) ? 1'b0 : 1'b1;
    end

    mm_acc_d = accept ? 1'b0 : (mm_acc_q | bit_mm);

    rsp_mm_d = 1'b0;
    mcnt_d   = mcnt_q;
    if ((state_q == SHIFT_OUT) && (state_d == DONE)) begin
      rsp_mm_d = mm_acc_d;
      if (mm_acc_d && (mcnt_q != 8'hFF)) begin
        mcnt_d = mcnt_q + 8'd1;
      end
    end else if (state_d == DONE) begin
      rsp_mm_d = rsp_mm_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      exp_q    <= '0;
      mm_acc_q <= 1'b0;
      rsp_mm_q <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      exp_q    <= exp_d;
      mm_acc_q <= mm_acc_d;
      rsp_mm_q <= rsp_mm_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign rsp_mismatch_o = rsp_mm_q;
  assign mismatch_cnt_o = mcnt_q;
`endif

endmodule

// File: tb/tb_sram_scan_sequencer.sv
// Bench for sram_scan_sequencer: behavioural scan chain plus packet-level expectations.
`timescale 1ns/1ps
module tb_sram_scan_sequencer;
  import sram_scan_pkg::*;

  localparam int W      = SCAN_WIDTH;
  localparam int CSB    = 1;
  localparam int WR_LAT = W + CSB + 1;
  localparam int RD_LAT = 2 * W + CSB + 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid_i, cmd_ready_o, cmd_read_i;
  logic [W-1:0] cmd_data_i;
  logic         rsp_valid_o, rsp_ready_i;
  logic [W-1:0] rsp_data_o;
  logic         scan_en_o, scan_out_o, scan_in_i, sram_load_o, global_csb_o;
  logic [W-1:0] exp_data_tb;
`ifdef SRAM_SCAN_CHECK_EN
  logic         rsp_mismatch_o;
  logic [7:0]   mismatch_cnt_o;
`endif

  always #5 clk = ~clk;

  sram_scan_sequencer #(.SCAN_WIDTH(W), .CSB_CYCLES(CSB)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_read_i   (cmd_read_i),
    .cmd_data_i   (cmd_data_i),
`ifdef SRAM_SCAN_CHECK_EN
    .exp_data_i     (exp_data_tb),
    .rsp_mismatch_o (rsp_mismatch_o),
    .mismatch_cnt_o (mismatch_cnt_o),
`endif
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .scan_en_o    (scan_en_o),
    .scan_out_o   (scan_out_o),
    .scan_in_i    (scan_in_i),
    .sram_load_o  (sram_load_o),
    .global_csb_o (global_csb_o)
  );

  // Scan chain: shifts on enabled edges, loads the SRAM read data into the din fields on load.
  logic [W-1:0] chain;
  logic [31:0]  ret_din0, ret_din1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (sram_load_o) begin
      chain[DIN0_MSB:DIN0_LSB] <= ret_din0;
      chain[DIN1_MSB:DIN1_LSB] <= ret_din1;
    end else if (scan_en_o) begin
      chain <= {chain[W-2:0], scan_out_o};
    end
  end
  assign scan_in_i = chain[W-1];

  int total = 0;
  int bad   = 0;

  int           o_valid_cyc, o_csb_low, o_csb_rise, o_load_cyc, o_load_cnt, o_en_cnt;
  logic [W-1:0] o_snap, o_data;
  logic         o_ready_at_valid, o_post_valid, o_post_ready, o_stable, o_mm;
  logic [7:0]   o_mcnt;

  function automatic logic [W-1:0] model_rsp(input logic [W-1:0] pkt, input logic rd,
                                             input logic [31:0] d0, input logic [31:0] d1);
    logic [W-1:0] r;
    if (!rd) return '0;
    r = pkt;
    r[DIN0_MSB:DIN0_LSB] = d0;
    r[DIN1_MSB:DIN1_LSB] = d1;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) p = {p[W-33:0], 32'($urandom)};
    return p;
  endfunction

  // Drives one command from IDLE and records what the pins did; callers judge the results.
  task automatic run_op(input logic [W-1:0] pkt, input logic rd, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [W-1:0] exp, input int hold);
    int   cyc;
    bit   seen;
    logic csb_prev;
    o_valid_cyc = -1; o_csb_low = 0; o_csb_rise = -1; o_load_cyc = -1; o_load_cnt = 0;
    o_en_cnt = 0; o_snap = '0; o_data = '0; o_ready_at_valid = 1'bx; o_stable = 1'b1;
    o_mm = 1'bx; o_mcnt = 8'hxx;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_read_i = rd; cmd_data_i = pkt;
    ret_din0 = d0; ret_din1 = d1; exp_data_tb = exp;
    rsp_ready_i = (hold == 0);
    cyc = 0; seen = 0; csb_prev = 1'b1;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      cmd_valid_i = 1'b0;
      if (scan_en_o) o_en_cnt++;
      if (!global_csb_o) begin
        if (o_csb_low == 0) o_snap = chain;
        o_csb_low++;
      end
      if (global_csb_o && !csb_prev) o_csb_rise = cyc;
      csb_prev = global_csb_o;
      if (sram_load_o) begin
        o_load_cnt++;
        o_load_cyc = cyc;
      end
      if (rsp_valid_o) begin
        seen = 1;
        o_valid_cyc = cyc;
        o_data = rsp_data_o;
        o_ready_at_valid = cmd_ready_o;
`ifdef SRAM_SCAN_CHECK_EN
        o_mm = rsp_mismatch_o;
        o_mcnt = mismatch_cnt_o;
`endif
      end
    end
    if (seen && hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        cmd_valid_i = 1'b1;
        cmd_data_i  = ~pkt;
        @(negedge clk);
        if (!rsp_valid_o || rsp_data_o !== o_data || cmd_ready_o) o_stable = 1'b0;
      end
      cmd_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
    end
    @(negedge clk);
    o_post_valid = rsp_valid_o;
    o_post_ready = cmd_ready_o;
  endtask

  task automatic test_reset();
    total++;
    if ({cmd_ready_o, rsp_valid_o, scan_en_o, scan_out_o, sram_load_o, global_csb_o} !== 6'b100001) begin
      bad++;
      $display("FAIL reset_pins got=%b want=100001",
               {cmd_ready_o, rsp_valid_o, scan_en_o, scan_out_o, sram_load_o, global_csb_o});
    end
    total++;
    if (rsp_data_o !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", rsp_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_ready_o, rsp_valid_o, scan_en_o, global_csb_o} !== 4'b1001) begin
      bad++; $display("FAIL reset_release got=%b want=1001", {cmd_ready_o, rsp_valid_o, scan_en_o, global_csb_o});
    end
  endtask

  task automatic test_reset_mid_shift();
    int vcount;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_read_i = 1'b1; cmd_data_i = rand_pkt();
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (49) @(negedge clk);
    total++;
    if (scan_en_o !== 1'b1 || global_csb_o !== 1'b1) begin
      bad++; $display("FAIL midshift_active got en=%b csb=%b want en=1 csb=1", scan_en_o, global_csb_o);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({cmd_ready_o, scan_en_o, global_csb_o, rsp_valid_o} !== 4'b1010) begin
      bad++; $display("FAIL midshift_async got=%b want=1010", {cmd_ready_o, scan_en_o, global_csb_o, rsp_valid_o});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({cmd_ready_o, scan_en_o, scan_out_o, sram_load_o, global_csb_o} !== 5'b10001) begin
      bad++; $display("FAIL midshift_after got=%b want=10001",
                      {cmd_ready_o, scan_en_o, scan_out_o, sram_load_o, global_csb_o});
    end
    vcount = 0;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid_o || !cmd_ready_o) vcount++;
    end
    total++;
    if (vcount != 0) begin
      bad++; $display("FAIL midshift_no_rsp got=%0d want=0", vcount);
    end
  endtask

  task automatic test_write();
    logic [W-1:0] pkt;
    pkt = pack_cmd(4'd0, 16'd1, 32'h0, 1'b0, 1'b0, 4'hF, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0);
    run_op(pkt, 1'b0, 32'h0, 32'h0, '0, 0);
    total++; if (o_valid_cyc != WR_LAT) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", o_valid_cyc, WR_LAT); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL wr_data got=%h want=0", o_data); end
    total++; if (o_snap !== pkt) begin bad++; $display("FAIL wr_serial got=%h want=%h", o_snap, pkt); end
    total++; if (o_csb_low != CSB) begin bad++; $display("FAIL wr_csb_low got=%0d want=%0d", o_csb_low, CSB); end
    total++; if (o_en_cnt != W) begin bad++; $display("FAIL wr_shift_cnt got=%0d want=%0d", o_en_cnt, W); end
    total++; if (o_load_cnt != 0) begin bad++; $display("FAIL wr_no_load got=%0d want=0", o_load_cnt); end
    total++; if (o_ready_at_valid !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b want=0", o_ready_at_valid); end
    total++; if ({o_post_valid, o_post_ready} !== 2'b01) begin
      bad++; $display("FAIL wr_handback got=%b want=01", {o_post_valid, o_post_ready});
    end
  endtask

  task automatic test_read();
    logic [W-1:0] pkt, want;
    pkt  = pack_cmd(4'd9, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd2, 32'h0, 1'b0, 1'b1, 4'h0);
    want = model_rsp(pkt, 1'b1, 32'd9, 32'd72);
    run_op(pkt, 1'b1, 32'd9, 32'd72, want, 0);
    total++; if (o_valid_cyc != RD_LAT) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", o_valid_cyc, RD_LAT); end
    total++; if (o_data !== want) begin bad++; $display("FAIL rd_data got=%h want=%h", o_data, want); end
    total++; if (o_snap !== pkt) begin bad++; $display("FAIL rd_serial got=%h want=%h", o_snap, pkt); end
    total++; if (o_csb_rise != W + CSB + 1) begin bad++; $display("FAIL rd_csb_rise got=%0d want=%0d", o_csb_rise, W + CSB + 1); end
    total++; if (o_load_cyc != o_csb_rise + 1 || o_load_cnt != 1) begin
      bad++; $display("FAIL rd_load got cyc=%0d n=%0d want cyc=%0d n=1", o_load_cyc, o_load_cnt, o_csb_rise + 1);
    end
    total++; if (o_en_cnt != 2 * W) begin bad++; $display("FAIL rd_shift_cnt got=%0d want=%0d", o_en_cnt, 2 * W); end
  endtask

  task automatic test_rom();
    logic [W-1:0] pkt, want;
    pkt  = pack_cmd(4'd11, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0);
    want = model_rsp(pkt, 1'b1, 32'd255, 32'd0);
    run_op(pkt, 1'b1, 32'd255, 32'd0, want, 0);
    total++; if (o_data[DIN0_MSB:DIN0_LSB] !== 32'd255) begin
      bad++; $display("FAIL rom_din0 got=%h want=000000ff", o_data[DIN0_MSB:DIN0_LSB]);
    end
    total++; if (o_data !== want) begin bad++; $display("FAIL rom_data got=%h want=%h", o_data, want); end
  endtask

  task automatic test_stall();
    logic [W-1:0] pkt, want;
    logic [31:0]  d0, d1;
    pkt = rand_pkt(); d0 = 32'($urandom); d1 = 32'($urandom);
    want = model_rsp(pkt, 1'b1, d0, d1);
    run_op(pkt, 1'b1, d0, d1, want, 20);
    total++; if (o_valid_cyc != RD_LAT) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", o_valid_cyc, RD_LAT); end
    total++; if (o_stable !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b want=1", o_stable); end
    total++; if (o_data !== want) begin bad++; $display("FAIL stall_data got=%h want=%h", o_data, want); end
    total++; if ({o_post_valid, o_post_ready} !== 2'b01) begin
      bad++; $display("FAIL stall_handback got=%b want=01", {o_post_valid, o_post_ready});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pkt, want;
    logic [31:0]  d0, d1;
    logic         rd;
    for (int n = 0; n < 6; n++) begin
      pkt = rand_pkt(); d0 = 32'($urandom); d1 = 32'($urandom);
      rd  = 1'($urandom_range(0, 1));
      want = model_rsp(pkt, rd, d0, d1);
      run_op(pkt, rd, d0, d1, want, 0);
      total++; if (o_valid_cyc != (rd ? RD_LAT : WR_LAT)) begin
        bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, o_valid_cyc, rd ? RD_LAT : WR_LAT);
      end
      total++; if (o_data !== want) begin bad++; $display("FAIL rand%0d_data got=%h want=%h", n, o_data, want); end
    end
  endtask

`ifdef SRAM_SCAN_CHECK_EN
  task automatic test_check();
    logic [W-1:0] pkt, good, exp;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pkt  = pack_cmd(4'd9, 16'd1, 32'h0, 1'b0, 1'b1, 4'h0, 16'd0, 32'h0, 1'b1, 1'b1, 4'h0);
    good = model_rsp(pkt, 1'b1, 32'h1234_5678, 32'h0);
    run_op(pkt, 1'b1, 32'h1234_5678, 32'h0, good, 0);
    total++; if ({o_mm, o_mcnt} !== {1'b0, 8'd0}) begin
      bad++; $display("FAIL chk_match got mm=%b cnt=%0d want mm=0 cnt=0", o_mm, o_mcnt);
    end
    exp = model_rsp(pkt, 1'b1, 32'hDEADBEEF, 32'h0);
    run_op(pkt, 1'b1, 32'hDEADBEEE, 32'h0, exp, 0);
    total++; if ({o_mm, o_mcnt} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL chk_mismatch got mm=%b cnt=%0d want mm=1 cnt=1", o_mm, o_mcnt);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_read_i = 1'b0; cmd_data_i = '0;
    rsp_ready_i = 1'b1; ret_din0 = '0; ret_din1 = '0; exp_data_tb = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_reset_mid_shift();
    test_write();
    test_read();
    test_rom();
    test_stall();
    test_random();
`ifdef SRAM_SCAN_CHECK_EN
    test_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
